// File: rtl/multimode_ff_bank.sv
`default_nettype none
// ============================================================================
// Module      : multimode_ff_bank
// Description : Bank of WIDTH independent flip-flop bits. The function is
//               chosen every cycle by 'mode' (SR, JK, D or T). The bank also
//               reports which bits changed, flags SR conflicts (S=R=1) and
//               keeps a saturating count of conflict cycles.
//
// Ports       : clk          - clock, all state updates on posedge
//               rst_n        - asynchronous active-low reset, release is
//                              synchronised to clk
//               en           - update enable (0 = every bit holds)
//               mode[1:0]    - 0 SR, 1 JK, 2 D, 3 T
//               a[WIDTH-1:0] - S / J / D / T per bit
//               b[WIDTH-1:0] - R / K per bit (ignored in D and T)
//               conflict_clr - synchronous clear of conflict_cnt
//               q, q_n       - registered state and its complement
//               changed      - 1 for the cycle after any q bit changed
//               conflict     - 1 for the cycle after an SR update with S=R=1
//               conflict_cnt - saturating count of conflict cycles
//
// Revision    : 1.0 - initial release
// ============================================================================
module multimode_ff_bank #(
    parameter int WIDTH   = 8,
    parameter int SR_BOTH = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             conflict_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             changed,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [1:0]       c_MODE_SR = 2'd0;
    localparam logic [1:0]       c_MODE_JK = 2'd1;
    localparam logic [1:0]       c_MODE_D  = 2'd2;
    localparam logic [1:0]       c_MODE_T  = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]       r_sync;
    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic             r_conflict;
    logic [CNT_W-1:0] r_cnt;

    logic             w_run;
    logic [WIDTH-1:0] w_both_val;
    logic [WIDTH-1:0] w_next;
    logic             w_conflict;

    // Reset release passes through two flops so the deassertion edge is
    // never seen asynchronously by the state registers; updates start once
    // the second flop has filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_run = r_sync[1];

    // Value taken by bits that see S=R=1 in SR mode.
    generate
        if (SR_BOTH == 1) begin : g_both_set
            assign w_both_val = '1;
        end else if (SR_BOTH == 2) begin : g_both_reset
            assign w_both_val = '0;
        end else if (SR_BOTH == 3) begin : g_both_toggle
            assign w_both_val = ~r_q;
        end else begin : g_both_hold
            assign w_both_val = r_q;
        end
    endgenerate

    always_comb begin
        w_next = r_q;
        case (mode)
            c_MODE_SR: w_next = (a & ~b) | (~a & ~b & r_q) | (a & b & w_both_val);
            c_MODE_JK: w_next = (a & ~r_q) | (~b & r_q);
            c_MODE_D:  w_next = a;
            c_MODE_T:  w_next = r_q ^ a;
            default:   w_next = r_q;
        endcase
    end

    // A conflict is an SR-mode S=R=1 on any bit, whatever SR_BOTH does with it.
    assign w_conflict = (mode == c_MODE_SR) && (|(a & b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            r_changed  <= 1'b0;
            r_conflict <= 1'b0;
            r_cnt      <= '0;
        end else if (!w_run) begin
            r_changed  <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            if (en) begin
                r_q        <= w_next;
                r_changed  <= |(w_next ^ r_q);
                r_conflict <= w_conflict;
            end else begin
                r_changed  <= 1'b0;
                r_conflict <= 1'b0;
            end
            // Clear has priority over a simultaneous increment.
            if (conflict_clr) begin
                r_cnt <= '0;
            end else if (en && w_conflict && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign q            = r_q;
    assign q_n          = ~r_q;
    assign changed      = r_changed;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multimode_ff_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_multimode_ff_bank
// Description : Self-checking bench for multimode_ff_bank. Three instances
//               share one stimulus: defaults, SR_BOTH=3, and CNT_W=2. A
//               per-bit behavioural model predicts every output; literal
//               expectations pin the model on directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multimode_ff_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       conflict_clr;

    logic [7:0] q0, qn0, q3, qn3, qc, qnc;
    logic       ch0, cf0, ch3, cf3, chc, cfc;
    logic [7:0] cnt0, cnt3;
    logic [1:0] cntc;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always #5 clk = ~clk;

    multimode_ff_bank #(.WIDTH(8), .SR_BOTH(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .conflict_clr(conflict_clr), .q(q0), .q_n(qn0), .changed(ch0),
        .conflict(cf0), .conflict_cnt(cnt0));

    multimode_ff_bank #(.WIDTH(8), .SR_BOTH(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .conflict_clr(conflict_clr), .q(q3), .q_n(qn3), .changed(ch3),
        .conflict(cf3), .conflict_cnt(cnt3));

    multimode_ff_bank #(.WIDTH(8), .SR_BOTH(0), .CNT_W(2)) dutc (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .conflict_clr(conflict_clr), .q(qc), .q_n(qnc), .changed(chc),
        .conflict(cfc), .conflict_cnt(cntc));

    // ---------------------------------------------------------------- model
    logic [7:0] m_q   [3];
    logic       m_chg [3];
    logic       m_cf  [3];
    int         m_cnt [3];
    int         m_ready;
    int         sr_both_of [3] = '{0, 3, 0};
    int         cnt_max_of [3] = '{255, 255, 3};

    function automatic logic next_bit(input int srb, input logic [1:0] m,
                                      input logic qb, input logic ab, input logic bb);
        logic r;
        r = qb;
        case (m)
            2'd0: begin
                if (ab && bb) begin
                    case (srb)
                        1:       r = 1'b1;
                        2:       r = 1'b0;
                        3:       r = !qb;
                        default: r = qb;
                    endcase
                end else if (ab) r = 1'b1;
                else if (bb)     r = 1'b0;
            end
            2'd1: begin
                if (ab && bb)    r = !qb;
                else if (ab)     r = 1'b1;
                else if (bb)     r = 1'b0;
            end
            2'd2:    r = ab;
            default: r = ab ? !qb : qb;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0;
            for (int k = 0; k < 3; k++) begin
                m_q[k] = 8'h00; m_chg[k] = 1'b0; m_cf[k] = 1'b0; m_cnt[k] = 0;
            end
        end else if (m_ready < 2) begin
            // Two edges pass after reset release before updates begin.
            m_ready = m_ready + 1;
            for (int k = 0; k < 3; k++) begin
                m_chg[k] = 1'b0; m_cf[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic [7:0] nq;
                logic       is_cf;
                is_cf = (mode == 2'd0) && ((a & b) != 8'h00);
                if (en) begin
                    for (int i = 0; i < 8; i++)
                        nq[i] = next_bit(sr_both_of[k], mode, m_q[k][i], a[i], b[i]);
                    m_chg[k] = (nq != m_q[k]);
                    m_cf[k]  = is_cf;
                    m_q[k]   = nq;
                end else begin
                    m_chg[k] = 1'b0;
                    m_cf[k]  = 1'b0;
                end
                if (conflict_clr)                                 m_cnt[k] = 0;
                else if (en && is_cf && m_cnt[k] < cnt_max_of[k]) m_cnt[k] = m_cnt[k] + 1;
            end
        end
    end

    // -------------------------------------------------------------- checking
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cycle, act, exp);
        end
    endtask

    task automatic cmp_inst(input int k, input logic [7:0] dq, input logic [7:0] dqn,
                            input logic dch, input logic dcf, input logic [7:0] dcnt);
        check($sformatf("model_q[%0d]", k),   {56'd0, dq},   {56'd0, m_q[k]});
        check($sformatf("q_n_inv[%0d]", k),   {56'd0, dqn},  {56'd0, ~dq});
        check($sformatf("model_chg[%0d]", k), {63'd0, dch},  {63'd0, m_chg[k]});
        check($sformatf("model_cf[%0d]", k),  {63'd0, dcf},  {63'd0, m_cf[k]});
        check($sformatf("model_cnt[%0d]", k), {56'd0, dcnt}, 64'(m_cnt[k]));
    endtask

    always @(negedge clk) begin
        cycle++;
        cmp_inst(0, q0, qn0, ch0, cf0, cnt0);
        cmp_inst(1, q3, qn3, ch3, cf3, cnt3);
        cmp_inst(2, qc, qnc, chc, cfc, {6'd0, cntc});
    end

    // ------------------------------------------------------------- stimulus
    task automatic step(input logic [1:0] m, input logic [7:0] aa, input logic [7:0] bb,
                        input logic e, input logic c);
        mode = m; a = aa; b = bb; en = e; conflict_clr = c;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; a = 8'h00; b = 8'h00; conflict_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // First edge after release must not update.
        step(2'd2, 8'hFF, 8'h00, 1'b1, 1'b0);
        check("sync_first_edge", {56'd0, q0}, 64'h00);
        step(2'd2, 8'hFF, 8'h00, 1'b1, 1'b0);
        step(2'd2, 8'hFF, 8'h00, 1'b1, 1'b0);
        check("sync_update", {56'd0, q0}, 64'hFF);
        step(2'd2, 8'h00, 8'h00, 1'b1, 1'b0);

        // SR set then JK toggle-all.
        step(2'd0, 8'h0F, 8'h00, 1'b1, 1'b0);
        check("sr_set", {56'd0, q0}, 64'h0F);
        step(2'd1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        check("jk_toggle", {56'd0, q0}, 64'hF0);
        check("jk_changed", {63'd0, ch0}, 64'd1);
        check("jk_no_conflict", {63'd0, cf0}, 64'd0);

        // SR conflicts: hold vs toggle, counting and saturation.
        step(2'd2, 8'h3C, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(2'd0, 8'h01, 8'h01, 1'b1, 1'b0);
            check("conflict_hold_q", {56'd0, q0}, 64'h3C);
            check("conflict_flag", {63'd0, cf0}, 64'd1);
            check("conflict_toggle_q", {56'd0, q3}, (k % 2 == 1) ? 64'h3D : 64'h3C);
        end
        check("conflict_cnt3", {56'd0, cnt0}, 64'd3);
        check("sat_cnt3", {62'd0, cntc}, 64'd3);
        step(2'd0, 8'h01, 8'h01, 1'b1, 1'b0);
        step(2'd0, 8'h01, 8'h01, 1'b1, 1'b0);
        check("sat_cnt5", {62'd0, cntc}, 64'd3);
        check("cnt5", {56'd0, cnt0}, 64'd5);
        step(2'd0, 8'h01, 8'h01, 1'b1, 1'b1);
        check("clr_wins", {62'd0, cntc}, 64'd0);
        check("clr_flag_kept", {63'd0, cfc}, 64'd1);
        check("clr_cnt0", {56'd0, cnt0}, 64'd0);

        // D, T and enable.
        step(2'd2, 8'h5A, 8'h00, 1'b1, 1'b0);
        check("d_load", {56'd0, q0}, 64'h5A);
        step(2'd3, 8'hFF, 8'h00, 1'b1, 1'b0);
        check("t_toggle", {56'd0, q0}, 64'hA5);
        check("t_changed", {63'd0, ch0}, 64'd1);
        step(2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        check("en0_hold", {56'd0, q0}, 64'hA5);
        check("en0_changed", {63'd0, ch0}, 64'd0);
        check("en0_conflict", {63'd0, cf0}, 64'd0);
        step(2'd0, 8'h01, 8'h01, 1'b1, 1'b0);
        check("pre_reset_cnt", {56'd0, cnt0}, 64'd1);

        // Asynchronous reset between edges.
        #1;
        rst_n = 1'b0;
        #1;
        check("async_q", {56'd0, q0}, 64'h00);
        check("async_qn", {56'd0, qn0}, 64'hFF);
        check("async_cnt", {56'd0, cnt0}, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) step(2'd0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
